// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port word memory between a fetch (I) and a data (D) requester
// Define MEM_ARB_STATS_EN to add grant and wait-cycle statistics outputs.
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_i_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_wait_cycles
`endif
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;

  logic starve_hit;
  logic grant_i;
  logic grant_d;
  logic last_cycle;

  // With STARVE_LIMIT = 0 the counter stays at 0, so I wins every tie.
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign grant_i    = (state_q == ST_IDLE) && i_req && (!d_req || starve_hit);
  assign grant_d    = (state_q == ST_IDLE) && d_req && !grant_i;
  assign last_cycle = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          owner_d  = OWN_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          starve_d = '0;
          cnt_d    = CW'(LATENCY);
          state_d  = ST_BUSY;
        end else if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (i_req && !starve_hit) begin
            starve_d = starve_q + SW'(1);
          end
          cnt_d   = CW'(LATENCY);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (last_cycle) begin
          state_d = ST_DONE;
          if (owner_q == OWN_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_dout;
          end else begin
            d_done_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_dout;
            end
          end
        end
      end
      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      starve_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  // Address and write data stay on the bus between accesses; only the enables qualify them.
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_read  = (state_q == ST_BUSY) && !we_q;
  assign mem_write = (state_q == ST_BUSY) && we_q && last_cycle;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_i_d;
  logic [31:0] stat_d_q, stat_d_d;
  logic [31:0] stat_w_q, stat_w_d;

  always_comb begin
    stat_i_d = stat_i_q + {31'd0, grant_i};
    stat_d_d = stat_d_q + {31'd0, grant_d};
    stat_w_d = stat_w_q + {31'd0, i_req && (owner_q != OWN_I)}
                        + {31'd0, d_req && (owner_q != OWN_D)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_w_q <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
      stat_w_q <= stat_w_d;
    end
  end

  assign stat_i_grants    = stat_i_q;
  assign stat_d_grants    = stat_d_q;
  assign stat_wait_cycles = stat_w_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int STV = 4;
  localparam int NW  = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        i_done, d_done, mem_read, mem_write;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_i_grants, stat_d_grants, stat_wait_cycles;
`endif

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
  endfunction

  // Memory seen by the DUT: async read, write on posedge.
  logic [31:0] ram [0:63];
  bit          ram_v [0:63];
  assign mem_dout = ram_v[mem_addr[7:2]] ? ram[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_addr[7:2]]   <= mem_din;
      ram_v[mem_addr[7:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] ram_word(input int i);
    return ram_v[i] ? ram[i] : init_word(i);
  endfunction

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
  endtask

  // Model state: per-window expected outputs scheduled at grant time.
  int          cyc = 0;
  int          next_free = 0;
  int          starve = 0;
  bit          exp_rd [NW];
  bit          exp_wr [NW];
  bit          exp_id [NW];
  bit          exp_dd [NW];
  logic [31:0] exp_addr [NW];
  logic [31:0] exp_din [NW];
  logic [31:0] m_ir = '0;
  logic [31:0] m_dr = '0;
  bit          pend_v = 1'b0, pend_i = 1'b0, pend_we = 1'b0;
  int          pend_win = 0;
  logic [31:0] pend_addr = '0, pend_wd = '0;
  logic [31:0] mm [0:63];
  bit          mm_v [0:63];
  byte         model_order [$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return mm_v[a[7:2]] ? mm[a[7:2]] : init_word(int'(a[7:2]));
  endfunction

  task automatic run_model();
    bit gi;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int k = 0; k <= LAT + 2; k++) begin
          exp_rd[cyc+k] = 1'b0; exp_wr[cyc+k] = 1'b0;
          exp_id[cyc+k] = 1'b0; exp_dd[cyc+k] = 1'b0;
        end
        pend_v = 1'b0; m_ir = '0; m_dr = '0; starve = 0; next_free = cyc + 1;
      end else begin
        if (pend_v && cyc == pend_win) begin
          if (pend_we) begin
            mm[pend_addr[7:2]] = pend_wd; mm_v[pend_addr[7:2]] = 1'b1;
          end else if (pend_i) m_ir = mw(pend_addr);
          else m_dr = mw(pend_addr);
          pend_v = 1'b0;
        end
        if (cyc >= next_free && (i_req || d_req)) begin
          gi = i_req && (!d_req || starve == STV);
          if (gi) starve = 0;
          else if (i_req && starve < STV) starve++;
          pend_v = 1'b1; pend_i = gi; pend_we = gi ? 1'b0 : d_we;
          pend_addr = gi ? i_addr : d_addr; pend_wd = d_wdata; pend_win = cyc + LAT;
          for (int k = 0; k < LAT; k++) begin
            exp_rd[cyc+k] = !pend_we; exp_addr[cyc+k] = pend_addr;
          end
          if (pend_we) begin
            exp_wr[cyc+LAT-1] = 1'b1; exp_din[cyc+LAT-1] = pend_wd;
          end
          if (gi) exp_id[cyc+LAT] = 1'b1; else exp_dd[cyc+LAT] = 1'b1;
          next_free = cyc + LAT + 2;
          model_order.push_back(gi ? 8'h49 : 8'h44);
        end
      end
    end
  endtask

  int          rd_cnt = 0, wr_cnt = 0, id_cnt = 0, dd_cnt = 0;
  logic [31:0] last_wr_addr = '0, last_wr_din = '0;
  int          id_wins [$];
  byte         dut_order [$];

  task automatic run_checker();
    forever begin
      @(negedge clk);
      if (cyc > 0 && cyc < NW) begin
        chk("mem_read", 32'(mem_read), 32'(exp_rd[cyc]));
        chk("mem_write", 32'(mem_write), 32'(exp_wr[cyc]));
        chk("i_done", 32'(i_done), 32'(exp_id[cyc]));
        chk("d_done", 32'(d_done), 32'(exp_dd[cyc]));
        if (exp_rd[cyc] || exp_wr[cyc]) chk("mem_addr", mem_addr, exp_addr[cyc]);
        if (exp_wr[cyc]) chk("mem_din", mem_din, exp_din[cyc]);
        chk("i_rdata", i_rdata, m_ir);
        chk("d_rdata", d_rdata, m_dr);
      end
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++; last_wr_addr = mem_addr; last_wr_din = mem_din;
      end
      if (i_done) begin
        id_cnt++; id_wins.push_back(cyc); dut_order.push_back(8'h49);
      end
      if (d_done) begin
        dd_cnt++; dut_order.push_back(8'h44);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic access(input bit is_i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
    if (is_i) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end
    lat = 0;
    do begin
      step(); lat++;
    end while (!(is_i ? i_done : d_done) && lat < 30);
    if (is_i) i_req = 1'b0; else d_req = 1'b0;
  endtask

  logic [31:0] t3_addr [3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] t3_exp [3]  = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
  string       exp_ord = "DDDDIDDDDI";

  initial begin
    int lat, r0, w0, i0, d0, base, mbase, n;
    fork
      run_model();
      run_checker();
    join_none

    repeat (3) step();
    chk("reset_enables", {28'd0, mem_read, mem_write, i_done, d_done}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    step();

    // D read
    r0 = rd_cnt; i0 = id_cnt;
    access(1'b0, 1'b0, 32'h10, 32'h0, lat);
    chk("t1_latency", 32'(lat), 32'(LAT + 1));
    chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("t1_read_cycles", 32'(rd_cnt - r0), 32'd2);
    chk("t1_no_i_done", 32'(id_cnt - i0), 32'd0);

    // D write
    step();
    w0 = wr_cnt;
    access(1'b0, 1'b1, 32'h20, 32'h12345678, lat);
    chk("t2_latency", 32'(lat), 32'(LAT + 1));
    chk("t2_write_cycles", 32'(wr_cnt - w0), 32'd1);
    chk("t2_write_addr", last_wr_addr, 32'h20);
    chk("t2_write_data", last_wr_din, 32'h12345678);
    chk("t2_d_rdata_kept", d_rdata, 32'hDEADBEEF);

    // I only, re-asserting the cycle after each done
    for (int k = 0; k < 3; k++) begin
      step();
      access(1'b1, 1'b0, t3_addr[k], 32'h0, lat);
      chk("t3_latency", 32'(lat), 32'(LAT + 1));
      chk("t3_i_rdata", i_rdata, t3_exp[k]);
    end
    n = id_wins.size();
    chk("t3_spacing_a", 32'(id_wins[n-1] - id_wins[n-2]), 32'd4);
    chk("t3_spacing_b", 32'(id_wins[n-2] - id_wins[n-3]), 32'd4);

    // Both requesting continuously
    step();
    base = dut_order.size(); mbase = model_order.size();
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    n = 0;
    while (dut_order.size() < base + 10 && n < 300) begin
      step(); n++;
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t4_grant_order", (dut_order.size() > base + k) ? 32'(dut_order[base+k]) : 32'hFFFF_FFFF,
          32'(exp_ord[k]));
      chk("t4_model_order", (model_order.size() > mbase + k) ? 32'(model_order[mbase+k]) : 32'hFFFF_FFFF,
          32'(exp_ord[k]));
    end

    // Reset during the first BUSY cycle of a D write
    step();
    w0 = wr_cnt; d0 = dd_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55AA55AA;
    step();
    chk("t5_busy_no_write_yet", 32'(mem_write), 32'd0);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    step();
    chk("t5_rst_enables", {28'd0, mem_read, mem_write, i_done, d_done}, 32'h0);
    chk("t5_rst_mem_addr", mem_addr, 32'h0);
    chk("t5_rst_mem_din", mem_din, 32'h0);
    chk("t5_rst_d_rdata", d_rdata, 32'h0);
    chk("t5_rst_i_rdata", i_rdata, 32'h0);
    reset = 1'b0;
    step(); step();
    chk("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("t5_no_d_done", 32'(dd_cnt - d0), 32'd0);
    chk("t5_ram_untouched", ram_word(12), 32'hA000_000C);
    access(1'b0, 1'b0, 32'h30, 32'h0, lat);
    chk("t5_post_latency", 32'(lat), 32'(LAT + 1));
    chk("t5_post_rdata", d_rdata, 32'hA000_000C);

    // Three D and two I accesses since the last reset
    step();
    access(1'b0, 1'b1, 32'h34, 32'hCAFEF00D, lat);
    step();
    access(1'b0, 1'b0, 32'h34, 32'h0, lat);
    chk("t6_d_rdata", d_rdata, 32'hCAFEF00D);
    step();
    access(1'b1, 1'b0, 32'h4, 32'h0, lat);
    chk("t6_i_rdata_a", i_rdata, 32'hA000_0001);
    step();
    access(1'b1, 1'b0, 32'h8, 32'h0, lat);
    chk("t6_i_rdata_b", i_rdata, 32'hA000_0002);
`ifdef MEM_ARB_STATS_EN
    step();
    chk("stat_d_grants", stat_d_grants, 32'd3);
    chk("stat_i_grants", stat_i_grants, 32'd2);
    reset = 1'b1;
    step();
    chk("stat_d_cleared", stat_d_grants, 32'd0);
    chk("stat_i_cleared", stat_i_grants, 32'd0);
    chk("stat_w_cleared", stat_wait_cycles, 32'd0);
    reset = 1'b0;
`endif
    step(); step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word memory between an instruction-fetch requester (I, read-only) and a data requester (D, read/write).
- Sequences each access over a configurable number of memory cycles and returns read data through a registered done pulse.
- By default D has priority over I. A starvation limit guarantees that I makes forward progress.
- Sits between the pipeline's fetch/mem stages and a shared DataMemory-style array: async read, write on posedge.

Parameters:
LATENCY, 2, memory cycles per access (must be ≥1); width of the busy counter is ceil(log2(LATENCY+1)).
STARVE_LIMIT, 4, consecutive D grants made while i_req is pending before I is forced; 0 = I always wins ties.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  I request; level, held until i_done
i_addr  in  32  I byte address
i_done  out  1  one-cycle pulse, I access complete
i_rdata  out  32  I read data, valid while i_done=1, held after
d_req  in  1  D request; level, held until d_done
d_we  in  1  1=write, 0=read
d_addr  in  32  D byte address
d_wdata  in  32  D write data
d_done  out  1  one-cycle pulse, D access complete
d_rdata  out  32  D read data (reads only), valid while d_done=1
mem_addr  out  32  address to memory
mem_din  out  32  write data to memory
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_dout  in  32  async read data from memory

Behaviour:
- Reset values: every output 0, state IDLE, busy counter 0, starve counter 0, owner = none.
- Reset dominates every other condition at the edge.
  - Mid-access reset aborts the access.
  - No done pulse is produced.
  - mem_read/mem_write are 0 from the next cycle on.
- IDLE:
  - Requests are sampled at the clock edge.
  - If only one requester asserts, it is granted.
  - If both assert, D is granted, unless starve_cnt == STARVE_LIMIT, in which case I is granted.
  - On grant: latch owner, address and (for D) we/wdata into internal registers; load the busy counter with LATENCY; go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_addr/mem_din are driven from the latched registers.
  - mem_read = 1 for reads, for all LATENCY cycles.
  - mem_write = 1 only in the final BUSY cycle: exactly one write per access.
  - The counter decrements each cycle. On the final cycle (counter == 1), mem_dout is captured into i_rdata or d_rdata (reads only), and the state goes to DONE.
- DONE:
  - The owner's done output is 1 for exactly this cycle. Memory enables are 0.
  - Requests are ignored in this state. The next state is always IDLE.
- Requester rule:
  - Keep req and request fields stable from assertion until the done pulse.
  - Req may be re-asserted with new fields in the cycle following done; that request is sampled in IDLE.
  - Address and data changes during BUSY have no effect because they were latched at grant.
- Latency: access sampled in IDLE → done pulses LATENCY+1 cycles later. Back-to-back throughput is one access per LATENCY+2 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when D is granted while i_req=1.
  - Clears when I is granted.
  - Unchanged otherwise.
- rdata registers hold their last captured value until the next read by the same owner. D writes do not modify d_rdata.
- Addresses are passed through unmodified; the memory performs the >>2 word indexing.
- mem_addr/mem_din hold their last values when idle; only the enables qualify them.
- The two done outputs are never asserted in the same cycle.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs stat_i_grants[31:0], stat_d_grants[31:0] and stat_wait_cycles[31:0].
  - stat_i_grants / stat_d_grants: wrapping counts of grants per requester.
  - stat_wait_cycles: counts cycles in which a req is 1 but that requester is not the current owner.
  - Counting applies in any state, per requester, so both requesters can add 1 in the same cycle.
  - All counters clear on reset.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- LATENCY=2; D read: d_addr=0x10, mem returns 0xDEADBEEF → mem_read high 2 cycles, d_done 3 cycles after sample, d_rdata=0xDEADBEEF, i_done stays 0.
- D write: d_addr=0x20, d_wdata=0x12345678 → mem_write high exactly 1 cycle (second BUSY cycle) with mem_addr=0x20, mem_din=0x12345678; d_rdata unchanged.
- Both requesting continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I…; I is never starved.
- I only: i_addr=0x0,0x4,0x8 back-to-back, re-asserting the cycle after each done → i_done every 4 cycles, i_rdata follows memory contents.
- Reset asserted during the first BUSY cycle of a D write → no mem_write pulse, no d_done, all outputs 0 next cycle; a new request after reset completes normally.
- MEM_ARB_STATS_EN defined, 3 D and 2 I accesses → stat_d_grants=3, stat_i_grants=2; after reset both read 0.
